// File: rtl/sr_ff_checker_pkg.sv
// Shared encodings for the SR flip-flop response checker: the {s,r}
// request codes and the two-state reference model state type.
package sr_chk_pkg;

    // {s,r} request encodings as seen on the flip-flop inputs
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_ILL  = 2'b11;

    // Reference model state: the observed cell has no reset, so the model
    // only becomes KNOWN once a set or reset request has been seen.
    typedef enum logic {
        ST_UNKNOWN = 1'b0,
        ST_KNOWN   = 1'b1
    } chk_state_e;

    // True when the request is the forbidden S=R=1 combination
    function automatic logic is_illegal(input logic [1:0] sr);
        return (sr == SR_ILL);
    endfunction

endpackage

// File: rtl/sr_ff_checker_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// synchronous clear has priority over a same-edge increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE_C = W'(1'b1);
    localparam logic [W-1:0] MAX_C = {W{1'b1}};

    logic [W-1:0] q_r;

    // Counter register: clear wins, otherwise increment until saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {W{1'b0}};
        end else if (clr) begin
            q_r <= {W{1'b0}};
        end else if (inc && (q_r != MAX_C)) begin
            q_r <= q_r + ONE_C;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sr_ff_checker.sv
// Response checker for an SR flip-flop sharing the s/r/clk nets. Tracks a
// reference model of the cell and compares the cell output one edge later.
module sr_ff_checker #(
    parameter int CNT_W            = 8,
    parameter bit STICKY_CLR_ON_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             s,
    input  logic             r,
    input  logic             dut_out,
    output logic             exp_out,
    output logic             known,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    import sr_chk_pkg::*;

    chk_state_e state_r;
    chk_state_e state_nxt_s;
    logic       exp_out_r;
    logic       exp_nxt_s;
    logic       err_r;
    logic       sticky_r;
    logic       sticky_nxt_s;
    logic       en_q_r;
    logic       cmp_s;
    logic       mis_s;
    logic       ill_s;
    logic       en_rise_s;

    // Model next state from {s,r}; the model follows the bus even when en is low
    always_comb begin
        state_nxt_s = state_r;
        exp_nxt_s   = exp_out_r;
        case ({s, r})
            SR_HOLD: begin
                state_nxt_s = state_r;
                exp_nxt_s   = exp_out_r;
            end
            SR_RST: begin
                state_nxt_s = ST_KNOWN;
                exp_nxt_s   = 1'b0;
            end
            SR_SET: begin
                state_nxt_s = ST_KNOWN;
                exp_nxt_s   = 1'b1;
            end
            SR_ILL: begin
                state_nxt_s = ST_UNKNOWN;
                exp_nxt_s   = exp_out_r;
            end
            default: begin
                state_nxt_s = state_r;
                exp_nxt_s   = exp_out_r;
            end
        endcase
    end

    // Compare, illegal-request and sticky-error decisions from pre-edge values
    always_comb begin
        cmp_s     = en && (state_r == ST_KNOWN);
        mis_s     = cmp_s && (dut_out != exp_out_r);
        ill_s     = en && is_illegal({s, r});
        en_rise_s = en && !en_q_r;
        if (clr) begin
            sticky_nxt_s = 1'b0;
        end else if (mis_s) begin
            sticky_nxt_s = 1'b1;
        end else if (STICKY_CLR_ON_EN && en_rise_s) begin
            sticky_nxt_s = 1'b0;
        end else begin
            sticky_nxt_s = sticky_r;
        end
    end

    // Model state, expected value, error pulse, sticky flag and enable history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_UNKNOWN;
            exp_out_r <= 1'b0;
            err_r     <= 1'b0;
            sticky_r  <= 1'b0;
            en_q_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            exp_out_r <= exp_nxt_s;
            err_r     <= mis_s;
            sticky_r  <= sticky_nxt_s;
            en_q_r    <= en;
        end
    end

    sat_counter #(.W(CNT_W)) u_chk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (cmp_s),
        .q     (chk_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (mis_s),
        .q     (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_illegal_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (ill_s),
        .q     (illegal_cnt)
    );

    assign exp_out    = exp_out_r;
    assign known      = (state_r == ST_KNOWN);
    assign err        = err_r;
    assign err_sticky = sticky_r;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: the bench plays the observed SR flip-flop (with
// optional output corruption) and keeps a behavioural model of the checker.
module tb_sr_ff_checker;

    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic s = 1'b0;
    logic r = 1'b0;
    logic dut_out = 1'b0;
    logic exp_out, known, err, err_sticky;
    logic [CNT_W-1:0] chk_cnt, err_cnt, illegal_cnt;

    always #5 clk = ~clk;

    sr_ff_checker #(.CNT_W(CNT_W), .STICKY_CLR_ON_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .s           (s),
        .r           (r),
        .dut_out     (dut_out),
        .exp_out     (exp_out),
        .known       (known),
        .err         (err),
        .err_sticky  (err_sticky),
        .chk_cnt     (chk_cnt),
        .err_cnt     (err_cnt),
        .illegal_cnt (illegal_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // behavioural checker model
    bit m_known, m_val, m_err, m_sticky, m_en_prev;
    int m_chk, m_errc, m_ill;
    // the flip-flop the bench emulates (no reset, powers up arbitrary)
    bit ff_q = 1'b0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_known = 1'b0; m_val = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_en_prev = 1'b0;
        m_chk = 0; m_errc = 0; m_ill = 0;
    endtask

    task automatic model_edge(input bit ms, input bit mr, input bit men, input bit mclr, input bit mdut);
        bit cmp, mis;
        cmp = men && m_known;
        mis = cmp && (mdut != m_val);
        m_err = mis;
        if (mclr) begin
            m_chk = 0; m_errc = 0; m_ill = 0; m_sticky = 1'b0;
        end else begin
            m_chk  = sat(m_chk + int'(cmp));
            m_errc = sat(m_errc + int'(mis));
            m_ill  = sat(m_ill + int'(men && ms && mr));
            if (mis) m_sticky = 1'b1;
            else if (men && !m_en_prev) m_sticky = 1'b0;
        end
        if (ms && !mr) begin m_known = 1'b1; m_val = 1'b1; end
        else if (!ms && mr) begin m_known = 1'b1; m_val = 1'b0; end
        else if (ms && mr) m_known = 1'b0;
        m_en_prev = men;
    endtask

    // One clock: drive at negedge, update models at posedge, return 1 ns later
    task automatic step(input bit ss, input bit rr, input bit ee, input bit cc, input bit flip);
        @(negedge clk);
        s = ss; r = rr; en = ee; clr = cc;
        dut_out = ff_q ^ flip;
        @(posedge clk);
        model_edge(ss, rr, ee, cc, dut_out);
        if (ss && !rr) ff_q = 1'b1;
        else if (!ss && rr) ff_q = 1'b0;
        else if (ss && rr) ff_q = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; s = 1'b0; r = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({exp_out, known, err, err_sticky} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=0000", {exp_out, known, err, err_sticky});
        end
        vectors++;
        if ({chk_cnt, err_cnt, illegal_cnt} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_counters got=%b exp=000000", {chk_cnt, err_cnt, illegal_cnt});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            vectors++;
            if (known !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d known=%b err=%b exp=0/0", i, known, err);
            end
        end
        vectors++;
        if (chk_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold_chk got=%0d exp=0", chk_cnt);
        end
    endtask

    task automatic test_sequence();
        bit [1:0] seq [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(seq[i][1], seq[i][0], 1'b1, 1'b0, 1'b0);
            vectors++;
            if (known !== m_known || err !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_step%0d known=%b err=%b exp=%b/0", i, known, err, m_known);
            end
        end
        vectors++;
        if (illegal_cnt !== 2'd2 || err_cnt !== 2'd0 || chk_cnt !== 2'd3) begin
            miscompares++;
            $display("FAIL seq_counts ill=%0d err=%0d chk=%0d exp=2/0/3", illegal_cnt, err_cnt, chk_cnt);
        end
        vectors++;
        if (err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_sticky got=%b exp=0", err_sticky);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (err !== 1'b1 || err_cnt !== 2'd1 || err_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_pulse err=%b cnt=%0d sticky=%b exp=1/1/1", err, err_cnt, err_sticky);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (err !== 1'b0 || err_sticky !== 1'b1 || err_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL mis_after err=%b sticky=%b cnt=%0d exp=0/1/1", err, err_sticky, err_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            vectors++;
            if (err !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_err cyc=%0d got=%b exp=1", i, err);
            end
        end
        vectors++;
        if (err_cnt !== 2'd3 || chk_cnt !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_counts err=%0d chk=%0d exp=3/3", err_cnt, chk_cnt);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({chk_cnt, err_cnt, illegal_cnt} !== 6'd0 || err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clr cnts=%b sticky=%b exp=0/0", {chk_cnt, err_cnt, illegal_cnt}, err_sticky);
        end
        vectors++;
        if (exp_out !== 1'b0 || known !== 1'b1 || err !== m_err) begin
            miscompares++;
            $display("FAIL sat_clr_model exp_out=%b known=%b err=%b exp=0/1/%b", exp_out, known, err, m_err);
        end
    endtask

    task automatic test_en_low();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (err !== 1'b0 || known !== 1'b1) begin
            miscompares++;
            $display("FAIL enlow_set err=%b known=%b exp=0/1", err, known);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (err !== 1'b0 || illegal_cnt !== 2'd0 || known !== 1'b0) begin
            miscompares++;
            $display("FAIL enlow_ill err=%b ill=%0d known=%b exp=0/0/0", err, illegal_cnt, known);
        end
        vectors++;
        if (err_sticky !== 1'b1 || chk_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL enlow_hold sticky=%b chk=%0d exp=1/1", err_sticky, chk_cnt);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (err_sticky !== 1'b0 || err_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL enrise_sticky sticky=%b errcnt=%0d exp=0/1", err_sticky, err_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({exp_out, known, err, err_sticky} !== 4'b0000 || {chk_cnt, err_cnt, illegal_cnt} !== 6'd0) begin
            miscompares++;
            $display("FAIL async_rst flags=%b cnts=%b exp=0/0", {exp_out, known, err, err_sticky},
                     {chk_cnt, err_cnt, illegal_cnt});
        end
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (known !== 1'b0 || err !== 1'b0 || chk_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL async_release known=%b err=%b chk=%0d exp=0/0/0", known, err, chk_cnt);
        end
    endtask

    task automatic test_random();
        bit rs, rr, re, rc, rf;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 9) != 0);
            rc = ($urandom_range(0, 24) == 0);
            rf = ($urandom_range(0, 6) == 0);
            step(rs, rr, re, rc, rf);
            vectors++;
            if ({known, err, err_sticky} !== {m_known, m_err, m_sticky}) begin
                miscompares++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {known, err, err_sticky},
                         {m_known, m_err, m_sticky});
            end
            vectors++;
            if (m_known && exp_out !== m_val) begin
                miscompares++;
                $display("FAIL rnd_exp_out cyc=%0d got=%b exp=%b", i, exp_out, m_val);
            end
            vectors++;
            if (chk_cnt !== m_chk[CNT_W-1:0] || err_cnt !== m_errc[CNT_W-1:0] ||
                illegal_cnt !== m_ill[CNT_W-1:0]) begin
                miscompares++;
                $display("FAIL rnd_counts cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                         chk_cnt, err_cnt, illegal_cnt, m_chk, m_errc, m_ill);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mismatch();
        test_saturation();
        test_en_low();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
